// File: rtl/shiftadd_mult_issuer_pkg.sv
// Shared definitions for the shift-add multiplier issue stage: FSM encoding
// and product-width helpers.
package mult_pkg;

    localparam int WIDTH_DEF = 4;

    function automatic int prod_w(input int width);
        return 2 * width + 1;
    endfunction

    localparam int PROD_W = prod_w(WIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/shiftadd_mult_issuer_if.sv
// Bundles the operand input, multiplier side and result output of the issuer.
// slave is the issuer's view, master the environment's view.
interface shiftadd_mult_issuer_if #(
    parameter int WIDTH = 4
);
    import mult_pkg::*;

    localparam int PW = prod_w(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_multiplier;
    logic [WIDTH-1:0] in_multiplicand;

    logic             mul_start;
    logic [WIDTH-1:0] mul_multiplier;
    logic [WIDTH-1:0] mul_multiplicand;
    logic [PW-1:0]    mul_product;
    logic             mul_done;

    logic             res_valid;
    logic             res_ready;
    logic [PW-1:0]    res_product;

    logic             busy;

    modport slave (
        input  in_valid, in_multiplier, in_multiplicand,
        input  mul_product, mul_done, res_ready,
        output in_ready, mul_start, mul_multiplier, mul_multiplicand,
        output res_valid, res_product, busy
    );

    modport master (
        output in_valid, in_multiplier, in_multiplicand,
        output mul_product, mul_done, res_ready,
        input  in_ready, mul_start, mul_multiplier, mul_multiplicand,
        input  res_valid, res_product, busy
    );

endinterface

// File: rtl/shiftadd_mult_issuer_fifo.sv
// Operand-pair FIFO: DEPTH entries of 2*WIDTH bits, power-of-two depth,
// pointers wrap naturally. Push when full and pop when empty are ignored.
module mult_operand_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [2*WIDTH-1:0] wdata,
    output logic [2*WIDTH-1:0] rdata,
    output logic               full,
    output logic               empty,
    output logic [CW-1:0]      count
);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push, do_pop;

    assign full    = (int'(count_q) == DEPTH);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; an entry is only ever read after it was written, and count guards that.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/shiftadd_mult_issuer.sv
// Issues queued operand pairs to the shift-add multiplier one at a time and
// captures each product into a downstream valid/ready result register.
module shiftadd_mult_issuer
    import mult_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    shiftadd_mult_issuer_if.slave  bus
);

    localparam int PW = prod_w(WIDTH);
    localparam int CW = $clog2(DEPTH + 1);

    state_e             state_q, state_d;
    logic               mul_start_q, mul_start_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic               res_valid_q, res_valid_d;
    logic [PW-1:0]      res_product_q, res_product_d;

    logic [2*WIDTH-1:0] fifo_head;
    logic               fifo_full, fifo_empty, fifo_push, pop_go;
    logic [CW-1:0]      fifo_count;

    assign fifo_push = bus.in_valid && !fifo_full;
    // A pop needs somewhere to put its eventual product.
    assign pop_go    = (state_q == ST_IDLE) && !fifo_empty &&
                       (!res_valid_q || bus.res_ready);

    mult_operand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (pop_go),
        .wdata ({bus.in_multiplier, bus.in_multiplicand}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        mul_start_d   = 1'b0;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        res_valid_d   = res_valid_q;
        res_product_d = res_product_q;

        if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pop_go) begin
                    {op_a_d, op_b_d} = fifo_head;
                    mul_start_d      = 1'b1;
                    state_d          = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.mul_done) begin
                    res_product_d = bus.mul_product;
                    res_valid_d   = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mul_start_q   <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            res_valid_q   <= 1'b0;
            res_product_q <= '0;
        end else begin
            state_q       <= state_d;
            mul_start_q   <= mul_start_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            res_valid_q   <= res_valid_d;
            res_product_q <= res_product_d;
        end
    end

    assign bus.in_ready         = !fifo_full;
    assign bus.mul_start        = mul_start_q;
    assign bus.mul_multiplier   = op_a_q;
    assign bus.mul_multiplicand = op_b_q;
    assign bus.res_valid        = res_valid_q;
    assign bus.res_product      = res_product_q;
    assign bus.busy             = (state_q != ST_IDLE);

    a_full_matches_count: assert property (@(posedge clk) disable iff (rst)
        fifo_full == (int'(fifo_count) == DEPTH));

endmodule

// File: tb/tb_shiftadd_mult_issuer.sv
// Scoreboard bench for shiftadd_mult_issuer with a behavioural multiplier
// that raises mul_done 8 cycles after each start.
module tb_shiftadd_mult_issuer;
    import mult_pkg::*;

    localparam int W  = 4;
    localparam int D  = 2;
    localparam int PW = PROD_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shiftadd_mult_issuer_if #(.WIDTH(W)) bus();

    shiftadd_mult_issuer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    logic [PW-1:0]  exp_q[$];
    logic [2*W-1:0] op_q[$];

    int     cyc = 0;
    int     acc_cyc = 0;
    int     starts = 0;
    int     consumed = 0;
    bit     chk_lat = 1'b0;
    bit     pend = 1'b0;
    int     mcnt = 0;
    logic [W-1:0] ma, mb;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model and output monitor, all at the falling edge.
    initial begin
        logic [2*W-1:0] op;
        bus.mul_done    = 1'b0;
        bus.mul_product = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                bus.mul_done = 1'b0;
                exp_q.delete();
                op_q.delete();
                continue;
            end
            if (bus.mul_done) begin
                bus.mul_done = 1'b0;
                pend = 1'b0;
                check("res_valid_at_d1", bus.res_valid, 1);
                check("idle_at_d1", bus.busy, 0);
            end else if (pend) begin
                check("op_a_stable", bus.mul_multiplier, ma);
                check("op_b_stable", bus.mul_multiplicand, mb);
                mcnt++;
                if (mcnt == 8) begin
                    bus.mul_done    = 1'b1;
                    bus.mul_product = PW'(ma) * PW'(mb);
                end
            end
            if (bus.mul_start) begin
                starts++;
                check("start_while_busy", pend, 0);
                pend = 1'b1;
                mcnt = 0;
                ma = bus.mul_multiplier;
                mb = bus.mul_multiplicand;
                check("start_has_job", op_q.size() != 0, 1);
                if (op_q.size() != 0) begin
                    op = op_q.pop_front();
                    check("issued_operands", {ma, mb}, op);
                end
                if (chk_lat) begin
                    check("start_latency", cyc - acc_cyc, 2);
                    chk_lat = 1'b0;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                op_q.push_back({bus.in_multiplier, bus.in_multiplicand});
                exp_q.push_back(PW'(bus.in_multiplier) * PW'(bus.in_multiplicand));
                acc_cyc = cyc;
            end
            if (bus.res_valid && bus.res_ready) begin
                check("res_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("res_product", bus.res_product, exp_q.pop_front());
                consumed++;
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_mul_start"}, bus.mul_start, 0);
        check({tag, "_mul_a"}, bus.mul_multiplier, 0);
        check({tag, "_mul_b"}, bus.mul_multiplicand, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_res_product"}, bus.res_product, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_multiplier = a;
        bus.in_multiplicand = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("push_accepted", ok, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && op_q.size() == 0 && !bus.busy && !bus.res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_busy(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.busy) begin ok = 1'b1; break; end
        end
        check("wait_busy", ok, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.in_multiplier = '0;
        bus.in_multiplicand = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Single job with first-issue latency
        chk_lat = 1'b1;
        push(4'd3, 4'd5);
        wait_idle(100);

        // Operand extremes
        push(4'd15, 4'd15);
        wait_idle(100);
        push(4'd0, 4'd9);
        wait_idle(100);

        // Back-to-back pushes fill the FIFO behind the first job
        base = consumed;
        push(4'd2, 4'd7);
        push(4'd4, 4'd4);
        push(4'd6, 4'd3);
        @(negedge clk);
        check("b2b_in_ready_full", bus.in_ready, 0);
        @(posedge clk); #1;
        wait_idle(200);
        check("b2b_delivered", consumed - base, 3);

        // Backpressure holds the result and blocks further issue
        bus.res_ready = 1'b0;
        base = starts;
        push(4'd1, 4'd1);
        push(4'd2, 4'd2);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("bp_res_valid", bus.res_valid, 1);
        check("bp_res_held", bus.res_product, 1);
        check("bp_single_start", starts - base, 1);
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        wait_idle(200);

        // Full FIFO refuses a third pair during WAIT
        push(4'd3, 4'd3);
        wait_busy(20);
        push(4'd1, 4'd2);
        push(4'd2, 4'd3);
        bus.in_valid = 1'b1;
        bus.in_multiplier = 4'd7;
        bus.in_multiplicand = 4'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_idle(200);

        // Asynchronous reset mid-WAIT with two pairs queued
        push(4'd4, 4'd4);
        wait_busy(20);
        push(4'd1, 4'd3);
        push(4'd2, 4'd5);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        base = starts;
        repeat (6) @(posedge clk);
        #1;
        check("post_reset_no_start", starts - base, 0);
        check("post_reset_idle", bus.busy, 0);
        chk_lat = 1'b1;
        push(4'd5, 4'd6);
        wait_idle(100);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/shiftadd_mult_issuer.md
# shiftadd_mult_issuer

Job-issue and result-capture stage wrapped around the shift-add multiplier. Buffers operand pairs from an upstream valid/ready source in a small FIFO and issues one job at a time to the multiplier with a one-cycle start pulse. It holds the operands stable until the multiplier's done, then captures the product into a result register offered downstream on a valid/ready port.

## Interface
- WIDTH, 4, operand width; product width is 2*WIDTH+1 (9 at default)
- DEPTH, 2, operand FIFO entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  FIFO can accept; = !full
- in_multiplier  in  WIDTH  multiplier operand
- in_multiplicand  in  WIDTH  multiplicand operand
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_multiplier  out  WIDTH  operand to multiplier, stable from start until done
- mul_multiplicand  out  WIDTH  operand to multiplier, stable from start until done
- mul_product  in  2*WIDTH+1  multiplier result
- mul_done  in  1  multiplier completion
- res_valid  out  1  result register holds an unconsumed product
- res_ready  in  1  downstream accepts result
- res_product  out  2*WIDTH+1  captured product
- busy  out  1  FSM not in IDLE

## Operation
- Push: in_valid && in_ready writes {multiplier, multiplicand} at the write pointer. No push when full; in_ready is low, so the pair is not taken.
- Pop: happens only in IDLE. Requires FIFO non-empty and result slot free. The slot is free when !res_valid || res_ready in that cycle.
- Push and pop in the same cycle are legal; the count is unchanged. There is no bypass: a pair pushed into an empty FIFO is poppable the next cycle at the earliest.
- Pointers wrap modulo DEPTH. Count is 0..DEPTH; full = (count==DEPTH), empty = (count==0).
- FSM states:
  - IDLE: on pop condition, latch the head pair into the operand registers and go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle; go to WAIT.
  - WAIT: the first cycle with mul_done=1 loads res_product<=mul_product and sets res_valid<=1, then goes to IDLE. mul_done is not sampled in the ISSUE cycle.
- Result register:
  - res_valid clears on res_valid && res_ready unless it is reloaded the same cycle; a reload wins.
  - res_product holds while res_valid && !res_ready.
- Operand registers change only on pop. mul_multiplier and mul_multiplicand are driven directly from them.
- Arithmetic: the block performs none; the product passes through unmodified at full 2*WIDTH+1 bits.

## Timing
- Reset values: in_ready=1, mul_start=0, mul_multiplier=0, mul_multiplicand=0, res_valid=0, res_product=0, busy=0; FSM=IDLE; FIFO empty; pointers=0.
- Accept in cycle N with an empty FIFO and free slot:
  - IDLE pop in N+1.
  - mul_start high in N+2.
  - WAIT from N+3.
- mul_done high in cycle D → res_valid high from D+1; FSM in IDLE at D+1.
- Back-to-back jobs: next mul_start earliest at D+2, if the slot is free at D+1 (res_ready=1 at D+1 or result consumed).
- Backpressure: with res_ready held low, no new job is issued. The FIFO keeps accepting until full.
- Reset mid-operation (any state): everything returns to reset values asynchronously and queued pairs are discarded. The multiplier shares rst, so no stale mul_done can follow.

## Structure
- Shared package mult_pkg:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_WAIT (2 bits)
  - product-width constant PROD_W = 2*WIDTH+1
- Sub-module mult_operand_fifo: parameterised WIDTH/DEPTH, storing 2*WIDTH-bit entries, with push/pop/full/empty/count and async active-high reset.
- Top level holds the FSM, operand registers, and result register.

## Test plan
- Single job: push 3×5; multiplier model asserts done 8 cycles after start → one mul_start pulse, operands 3/5 stable until done, res_product=15 with res_valid at D+1, consumed with res_ready=1.
- Max operands: push 15×15 → res_product=225; then 0×9 → 0.
- Back-to-back: push 2×7, 4×4, 6×3 on consecutive cycles with res_ready=1 → in_ready low after 2 queued, and results 14, 16, 18 delivered in order. No start is issued while the FSM is in ISSUE or WAIT.
- Backpressure: res_ready=0, push 1×1 then 2×2 → first result held at 1, no second mul_start. Raise res_ready → 1 consumed, then 4 delivered.
- Full FIFO: fill DEPTH entries during a WAIT and assert in_valid again → in_ready=0 and the pair is not accepted. Simultaneous push/pop at full is not possible; at count=1, push+pop leaves count=1.
- Reset mid-WAIT with 2 pairs queued → all outputs at reset values the same cycle and FIFO empty. After release, a new push 5×6 yields 30.
